// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding,
// fetch exception cause codes, FSM state encoding and the slot record.
package fetch_unit_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    localparam logic [3:0]  IF_EXC_MISALIGN = 4'd0;
    localparam logic [3:0]  IF_EXC_FAULT    = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_KILL  = 2'd2,
        ST_TRAP  = 2'd3
    } fetch_state_e;

    // One decode-bound entry: the output slot and the skid buffer share this shape.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
        logic [3:0]  cause;
    } slot_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a word acknowledged while decode is stalled.
// clear has priority over load, load over unload.
module fetch_skid_buffer
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  slot_t load_data,
    output logic  valid,
    output slot_t data
);

    logic  valid_q, valid_d;
    slot_t data_q, data_d;

    // Next-state selection for occupancy and payload.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Occupancy and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload is a single small register, so it is reset for deterministic simulation; a true memory array would not be.
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM with one request
// in flight, output slot to decode, and a one-entry skid buffer.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect targets trap
// with cause 0 instead of being truncated to a word boundary).
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = fetch_unit_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    input  logic        pc_redirect,
    input  logic [31:0] pc_branch_address,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic        if_exception,
    output logic [3:0]  if_exc_cause
);
    import fetch_unit_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;      // redirect target parked while KILL drains the old request
    logic [31:0]  redir_tgt, kill_tgt, exc_pc;
    logic         if_valid_q, if_valid_d;
    slot_t        slot_q, slot_d, fetched, skid_data;
    logic         skid_valid, skid_load, skid_unload, skid_clear;
    logic         ack_fire, data_acc, exc_load;

`ifdef FETCH_MISALIGN_EN
    assign redir_tgt = pc_branch_address;
`else
    assign redir_tgt = pc_branch_address & 32'hFFFF_FFFC;
`endif

    // KILL keeps the old address on the bus; no request while the skid holds a word.
    assign imem_req  = (state_q == ST_KILL) || ((state_q == ST_FETCH) && !skid_valid);
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign ack_fire  = imem_req && imem_ack;
    assign kill_tgt  = pc_redirect ? redir_tgt : tgt_q;

    assign fetched = '{instr: imem_err ? NOP_INSTR : imem_rdata,
                       pc:    pc_q,
                       exc:   imem_err,
                       cause: imem_err ? IF_EXC_FAULT : 4'd0};

    // FSM and PC next-state; also flags an accepted ack and a misaligned-target trap.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        data_acc = 1'b0;
        exc_load = 1'b0;
        exc_pc   = redir_tgt;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (pc_redirect) begin
                    if (imem_req && !imem_ack) begin
                        state_d = ST_KILL;
                        tgt_d   = redir_tgt;
                    end else if (is_misaligned(redir_tgt)) begin
                        state_d  = ST_TRAP;
                        exc_load = 1'b1;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (ack_fire) begin
                    data_acc = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    if (imem_err) state_d = ST_TRAP;
                end
            end
            ST_KILL: begin
                if (ack_fire) begin
                    if (is_misaligned(kill_tgt)) begin
                        state_d  = ST_TRAP;
                        exc_load = 1'b1;
                        exc_pc   = kill_tgt;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = kill_tgt;
                    end
                end else if (pc_redirect) begin
                    tgt_d = redir_tgt;
                end
            end
            ST_TRAP: begin
                if (pc_redirect) begin
                    if (is_misaligned(redir_tgt)) begin
                        exc_load = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = redir_tgt;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot: redirect flushes, else advance from skid first, then from the bus.
    always_comb begin
        if_valid_d  = if_valid_q;
        slot_d      = slot_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;
        if (exc_load) begin
            if_valid_d = 1'b1;
            slot_d     = '{instr: NOP_INSTR, pc: exc_pc, exc: 1'b1, cause: IF_EXC_MISALIGN};
            skid_clear = 1'b1;
        end else if (pc_redirect && (state_q != ST_IDLE)) begin
            if_valid_d   = 1'b0;
            slot_d.instr = NOP_INSTR;
            slot_d.exc   = 1'b0;
            slot_d.cause = 4'd0;
            skid_clear   = 1'b1;
        end else if (!if_valid_q || !id_stall) begin
            if (skid_valid) begin
                if_valid_d  = 1'b1;
                slot_d      = skid_data;
                skid_unload = 1'b1;
            end else if (data_acc) begin
                if_valid_d = 1'b1;
                slot_d     = fetched;
            end else begin
                if_valid_d   = 1'b0;
                slot_d.instr = NOP_INSTR;
                slot_d.exc   = 1'b0;
                slot_d.cause = 4'd0;
            end
        end else if (data_acc) begin
            skid_load = 1'b1;
        end
    end

    // State, PC, parked target and output slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_ADDR;
            tgt_q      <= RESET_ADDR;
            if_valid_q <= 1'b0;
            slot_q     <= '{instr: NOP_INSTR, pc: RESET_ADDR, exc: 1'b0, cause: 4'd0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            if_valid_q <= if_valid_d;
            slot_q     <= slot_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .unload    (skid_unload),
        .clear     (skid_clear),
        .load_data (fetched),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    assign if_valid       = if_valid_q;
    assign if_instruction = slot_q.instr;
    assign if_pc          = slot_q.pc;
    assign if_exception   = slot_q.exc;
    assign if_exc_cause   = slot_q.cause;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural instruction memory whose
// ack latency and fault address are set per scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        pc_redirect;
    logic [31:0] pc_branch_address;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        if_exception;
    logic [3:0]  if_exc_cause;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_delay;
    int          wait_cnt;
    bit          err_en;
    logic [31:0] err_addr;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .imem_err          (imem_err),
        .pc_redirect       (pc_redirect),
        .pc_branch_address (pc_branch_address),
        .id_stall          (id_stall),
        .if_valid          (if_valid),
        .if_instruction    (if_instruction),
        .if_pc             (if_pc),
        .if_exception      (if_exception),
        .if_exc_cause      (if_exc_cause)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    // Memory model: ack once the request has waited ack_delay cycles.
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = imem_ack ? word_at(imem_addr) : 32'h0;
    assign imem_err   = imem_ack && err_en && (imem_addr == err_addr);

    always @(posedge clk or posedge rst) begin
        if (rst)                        wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, check reset values, release; returns in the first FETCH cycle.
    task automatic do_reset(input int delay);
        rst               = 1'b1;
        id_stall          = 1'b0;
        pc_redirect       = 1'b0;
        pc_branch_address = 32'h0;
        err_en            = 1'b0;
        err_addr          = 32'h0;
        ack_delay         = delay;
        step();
        step();
        check("rst_req",   {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_instr", if_instruction, NOP);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_exc",   {27'b0, if_exception, if_exc_cause}, 32'd0);
        rst = 1'b0;
        step();
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        for (int i = 0; i < 50 && !(imem_req && imem_addr == a); i++) step();
        check(tag, imem_addr, a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Zero-wait streaming.
        do_reset(0);
        check("s_req0",  {31'b0, imem_req}, 32'd1);
        check("s_addr0", imem_addr, 32'h0);
        step();
        check("s_addr4", imem_addr, 32'h4);
        check("s_valid", {31'b0, if_valid}, 32'd1);
        check("s_pc0",   if_pc, 32'h0);
        check("s_ins0",  if_instruction, word_at(32'h0));
        step();
        check("s_addr8", imem_addr, 32'h8);
        check("s_pc4",   if_pc, 32'h4);

        // Three stall cycles: slot frozen on 0x4, word 0x8 parked, bus idle.
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_pc",    if_pc, 32'h4);
            check("st_instr", if_instruction, word_at(32'h4));
            check("st_req",   {31'b0, imem_req}, 32'd0);
        end
        id_stall = 1'b0;
        step();
        check("st_skid_pc", if_pc, 32'h8);
        check("st_addr",    imem_addr, 32'hC);
        step();
        check("st_pc_c",    if_pc, 32'hC);
        step();
        check("st_pc_10",   if_pc, 32'h10);

        // Slow memory, redirect while the first request is outstanding.
        do_reset(3);
        pc_redirect       = 1'b1;
        pc_branch_address = 32'h100;
        step();
        pc_redirect = 1'b0;
        check("k_req",   {31'b0, imem_req}, 32'd1);
        check("k_addr",  imem_addr, 32'h0);
        step();
        step();
        check("k_ack_old", {30'b0, imem_req, imem_ack}, 32'd3);
        check("k_addr_old", imem_addr, 32'h0);
        step();
        check("k_new_addr", imem_addr, 32'h100);
        check("k_nvalid",   {31'b0, if_valid}, 32'd0);
        for (int i = 0; i < 10 && !if_valid; i++) step();
        check("k_first_pc",  if_pc, 32'h100);
        check("k_first_ins", if_instruction, word_at(32'h100));

        // Redirect coinciding with the ack of 0x10.
        do_reset(0);
        wait_addr("r_at_10", 32'h10);
        pc_redirect       = 1'b1;
        pc_branch_address = 32'h200;
        step();
        pc_redirect = 1'b0;
        check("r_valid0", {31'b0, if_valid}, 32'd0);
        check("r_addr",   imem_addr, 32'h200);
        step();
        check("r_valid1", {31'b0, if_valid}, 32'd1);
        check("r_pc",     if_pc, 32'h200);

        // Access fault on 0x40.
        do_reset(0);
        err_en   = 1'b1;
        err_addr = 32'h40;
        wait_addr("e_at_40", 32'h40);
        step();
        err_en = 1'b0;
        check("e_valid", {31'b0, if_valid}, 32'd1);
        check("e_exc",   {31'b0, if_exception}, 32'd1);
        check("e_cause", {28'b0, if_exc_cause}, 32'd1);
        check("e_pc",    if_pc, 32'h40);
        check("e_instr", if_instruction, NOP);
        check("e_noreq", {31'b0, imem_req}, 32'd0);
        step();
        step();
        check("e_noreq2", {31'b0, imem_req}, 32'd0);
        pc_redirect       = 1'b1;
        pc_branch_address = 32'h80;
        step();
        pc_redirect = 1'b0;
        check("e_resume", imem_addr, 32'h80);
        check("e_req",    {31'b0, imem_req}, 32'd1);
        step();
        check("e_pc80",   if_pc, 32'h80);

        // Misaligned redirect target.
        pc_redirect       = 1'b1;
        pc_branch_address = 32'h102;
        step();
        pc_redirect = 1'b0;
`ifdef FETCH_MISALIGN_EN
        check("m_valid", {31'b0, if_valid}, 32'd1);
        check("m_exc",   {31'b0, if_exception}, 32'd1);
        check("m_cause", {28'b0, if_exc_cause}, 32'd0);
        check("m_pc",    if_pc, 32'h102);
        check("m_noreq", {31'b0, imem_req}, 32'd0);
`else
        check("m_valid", {31'b0, if_valid}, 32'd0);
        check("m_req",   {31'b0, imem_req}, 32'd1);
        check("m_addr",  imem_addr, 32'h100);
        step();
        check("m_pc",    if_pc, 32'h100);
        check("m_instr", if_instruction, word_at(32'h100));
`endif

        // Asynchronous reset in the middle of a slow request.
        do_reset(5);
        check("ar_req_pre", {31'b0, imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("ar_req_drop", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
